// File: rtl/key_debounce.sv
// Counter-based debounce and event detector for a synchronized slow input.
// Produces a debounced level, one-cycle press/release/long-press pulses and
// a wrap-around press counter.
module key_debounce #(
  parameter int unsigned DB_CYCLES   = 1000000,
  parameter int unsigned LONG_CYCLES = 50000000,
  parameter bit          ACTIVE_LOW  = 1'b1,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             clr_cnt,
  output logic             key_level,
  output logic             press_pulse,
  output logic             release_pulse,
  output logic             long_pulse,
  output logic [CNT_W-1:0] press_cnt
);

  localparam int unsigned DB_W   = $clog2(DB_CYCLES);
  localparam int unsigned HOLD_W = $clog2(LONG_CYCLES);

  localparam logic [DB_W-1:0]   DB_MAX   = DB_W'(DB_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESS_WAIT,
    ST_PRESSED,
    ST_RELEASE_WAIT
  } state_t;

  state_t             state_q, state_d;
  logic [DB_W-1:0]    cnt_q, cnt_d;
  logic [HOLD_W-1:0]  hcnt_q, hcnt_d;
  logic               long_done_q, long_done_d;
  logic               key_level_q, key_level_d;
  logic               press_pulse_q, press_pulse_d;
  logic               release_pulse_q, release_pulse_d;
  logic               long_pulse_q, long_pulse_d;
  logic [CNT_W-1:0]   press_cnt_q, press_cnt_d;

  logic               act_c;
  logic [HOLD_W-1:0]  hcnt_inc_c;
  logic [CNT_W-1:0]   cnt_base_c;

  // Normalize polarity: act=1 means the key is pressed.
  assign act_c      = din ^ ACTIVE_LOW;
  assign hcnt_inc_c = hcnt_q + HOLD_W'(1);

  // Next-state, debounce/hold counters and pulse generation.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    hcnt_d          = hcnt_q;
    long_done_d     = long_done_q;
    key_level_d     = key_level_q;
    press_pulse_d   = 1'b0;
    release_pulse_d = 1'b0;
    long_pulse_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        key_level_d = 1'b0;
        if (act_c) begin
          state_d = ST_PRESS_WAIT;
          cnt_d   = DB_W'(1);
        end else begin
          cnt_d = '0;
        end
      end

      ST_PRESS_WAIT: begin
        if (!act_c) begin
          // Bounce: throw the partial window away.
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DB_MAX) begin
          state_d       = ST_PRESSED;
          cnt_d         = '0;
          key_level_d   = 1'b1;
          press_pulse_d = 1'b1;
          hcnt_d        = '0;
          long_done_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + DB_W'(1);
        end
      end

      ST_PRESSED: begin
        if (!act_c) begin
          state_d = ST_RELEASE_WAIT;
          cnt_d   = DB_W'(1);
        end else begin
          cnt_d = '0;
          if (hcnt_q != HOLD_MAX) begin
            hcnt_d = hcnt_inc_c;
            // Fire once, on the edge the saturation value is reached.
            if ((hcnt_inc_c == HOLD_MAX) && !long_done_q) begin
              long_pulse_d = 1'b1;
              long_done_d  = 1'b1;
            end
          end
        end
      end

      ST_RELEASE_WAIT: begin
        if (act_c) begin
          // Release bounce: hold progress and long_done are kept.
          state_d = ST_PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == DB_MAX) begin
          state_d         = ST_IDLE;
          cnt_d           = '0;
          key_level_d     = 1'b0;
          release_pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + DB_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Press counter: clear takes priority over the old value, not over the increment.
  always_comb begin
    cnt_base_c  = clr_cnt ? '0 : press_cnt_q;
    press_cnt_d = press_pulse_d ? (cnt_base_c + CNT_W'(1)) : cnt_base_c;
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      cnt_q           <= '0;
      hcnt_q          <= '0;
      long_done_q     <= 1'b0;
      key_level_q     <= 1'b0;
      press_pulse_q   <= 1'b0;
      release_pulse_q <= 1'b0;
      long_pulse_q    <= 1'b0;
      press_cnt_q     <= '0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      hcnt_q          <= hcnt_d;
      long_done_q     <= long_done_d;
      key_level_q     <= key_level_d;
      press_pulse_q   <= press_pulse_d;
      release_pulse_q <= release_pulse_d;
      long_pulse_q    <= long_pulse_d;
      press_cnt_q     <= press_cnt_d;
    end
  end

  assign key_level     = key_level_q;
  assign press_pulse   = press_pulse_q;
  assign release_pulse = release_pulse_q;
  assign long_pulse    = long_pulse_q;
  assign press_cnt     = press_cnt_q;

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: vector table, hand-written reset sequences and a
// randomized run against a run-length reference model. Two instances share
// the stimulus, one active-high and one active-low fed with inverted din.
module tb_key_debounce;

  localparam int unsigned DB    = 4;
  localparam int unsigned LONG  = 16;
  localparam int unsigned CW    = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          din;
  logic          din_n;
  logic          clr;

  logic          lvl0, pp0, rp0, lp0;
  logic [CW-1:0] cnt0;
  logic          lvl1, pp1, rp1, lp1;
  logic [CW-1:0] cnt1;

  int n_vec = 0;
  int n_err = 0;

  assign din_n = ~din;

  always #5 clk = ~clk;

  key_debounce #(.DB_CYCLES(DB), .LONG_CYCLES(LONG), .ACTIVE_LOW(1'b0), .CNT_W(CW)) dut_hi (
    .clk(clk), .rst(rst), .din(din), .clr_cnt(clr),
    .key_level(lvl0), .press_pulse(pp0), .release_pulse(rp0),
    .long_pulse(lp0), .press_cnt(cnt0)
  );

  key_debounce #(.DB_CYCLES(DB), .LONG_CYCLES(LONG), .ACTIVE_LOW(1'b1), .CNT_W(CW)) dut_lo (
    .clk(clk), .rst(rst), .din(din_n), .clr_cnt(clr),
    .key_level(lvl1), .press_pulse(pp1), .release_pulse(rp1),
    .long_pulse(lp1), .press_cnt(cnt1)
  );

  // {level, press, release, long, cnt}
  typedef struct {
    logic       d;
    logic       c;
    logic [5:0] exp;
  } vec_t;

  vec_t tbl[$];

  // Reference model: level plus length of the current disagreeing run.
  bit m_level;
  int m_run;
  int m_hold;
  bit m_ldone;
  int m_cnt;
  bit m_pp, m_rp, m_lp;

  task automatic model_reset();
    m_level = 0; m_run = 0; m_hold = 0; m_ldone = 0; m_cnt = 0;
    m_pp = 0; m_rp = 0; m_lp = 0;
  endtask

  task automatic model_step(input bit a, input bit c);
    int nc;
    m_pp = 0; m_rp = 0; m_lp = 0;
    nc = c ? 0 : m_cnt;
    if (a != m_level) begin
      m_run = m_run + 1;
      if (m_run == DB) begin
        m_level = a;
        m_run   = 0;
        if (a) begin
          m_pp = 1; m_hold = 0; m_ldone = 0; nc = nc + 1;
        end else begin
          m_rp = 1;
        end
      end
    end else begin
      // Only cycles that were already settled as pressed count towards hold.
      if (a && m_run == 0 && m_hold < LONG - 1) begin
        m_hold = m_hold + 1;
        if (m_hold == LONG - 1 && !m_ldone) begin
          m_lp = 1; m_ldone = 1;
        end
      end
      m_run = 0;
    end
    m_cnt = nc % (1 << CW);
  endtask

  function automatic logic [5:0] model_exp();
    return {m_level, m_pp, m_rp, m_lp, CW'(m_cnt)};
  endfunction

  task automatic check(input string name, input logic [5:0] exp);
    logic [5:0] g0, g1;
    g0 = {lvl0, pp0, rp0, lp0, cnt0};
    g1 = {lvl1, pp1, rp1, lp1, cnt1};
    n_vec++;
    if (g0 !== exp) begin
      n_err++;
      $display("FAIL %s act_high: got lvl/pp/rp/lp/cnt=%b required %b", name, g0, exp);
    end
    n_vec++;
    if (g1 !== exp) begin
      n_err++;
      $display("FAIL %s act_low: got lvl/pp/rp/lp/cnt=%b required %b", name, g1, exp);
    end
  endtask

  task automatic step(input logic d, input logic c);
    din = d;
    clr = c;
    @(posedge clk);
    if (rst) model_reset();
    else     model_step(d, c);
    #1;
  endtask

  task automatic add(input logic d, input logic c, input logic lv, input logic pp,
                     input logic rp, input logic lp, input int cnt);
    vec_t v;
    v.d   = d;
    v.c   = c;
    v.exp = {lv, pp, rp, lp, CW'(cnt)};
    tbl.push_back(v);
  endtask

  // Clean press from idle: accept on the 4th active sample.
  task automatic add_press(input int prev, input int nxt, input bit clr_on_accept);
    for (int j = 0; j < 4; j++)
      add(1'b1, (j == 3) && clr_on_accept, j == 3, j == 3, 1'b0, 1'b0, (j == 3) ? nxt : prev);
  endtask

  task automatic add_release(input int cnt);
    for (int j = 0; j < 4; j++)
      add(1'b0, 1'b0, j != 3, 1'b0, j == 3, 1'b0, cnt);
  endtask

  initial begin
    int run_len;
    logic cur;
    logic bounce[7];

    // Clean press, 30 active samples: press at idx 3, long 15 cycles later.
    for (int i = 0; i < 30; i++)
      add(1'b1, 1'b0, i >= 3, i == 3, 1'b0, i == 18, (i >= 3) ? 1 : 0);
    add_release(1);
    // Press bounce 1,1,1,0,1,1,1,1.
    for (int i = 0; i < 8; i++)
      add((i != 3), 1'b0, i == 7, i == 7, 1'b0, 1'b0, (i == 7) ? 2 : 1);
    // Hold 10, release glitch 0,0,1, hold 5 more: long fires (hold not restarted).
    for (int i = 0; i < 10; i++) add(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2);
    add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2);
    add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2);
    add(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2);
    for (int i = 0; i < 5; i++) add(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, i == 4, 2);
    // Release bounce 0,0,1,0,0,0,0.
    bounce = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 7; i++)
      add(bounce[i], 1'b0, i != 6, 1'b0, i == 6, 1'b0, 2);
    // Counter clear, wrap, and clear coincident with acceptance.
    add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
    add_press(0, 1, 1'b0); add_release(1);
    add_press(1, 2, 1'b0); add_release(2);
    add_press(2, 3, 1'b0); add_release(3);
    add_press(3, 0, 1'b0); add_release(0);
    add_press(0, 1, 1'b1); add_release(1);
    add_press(1, 1, 1'b1);
    add(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
    add_release(0);

    // Reset state.
    rst = 1'b1; din = 1'b0; clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 6'b0);
    #2 rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].d, tbl[i].c);
      check($sformatf("table[%0d]", i), tbl[i].exp);
    end

    // Press so press_cnt is nonzero, then reset after 2 active samples.
    add_press(0, 0, 1'b0);
    tbl.delete();
    add_press(0, 1, 1'b0);
    add_release(1);
    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].d, tbl[i].c);
      check($sformatf("pre_rst[%0d]", i), tbl[i].exp);
    end
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    check("two_active", {1'b0, 1'b0, 1'b0, 1'b0, CW'(1)});
    #2 rst = 1'b1;
    #1 check("async_rst", 6'b0);
    step(1'b1, 1'b0);
    check("rst_held", 6'b0);
    #2 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0);
      check($sformatf("post_rst[%0d]", i),
            {i == 3, i == 3, 1'b0, 1'b0, CW'((i == 3) ? 1 : 0)});
    end

    // Randomized run against the model.
    rst = 1'b1;
    step(1'b0, 1'b0);
    #2 rst = 1'b0;
    model_reset();
    run_len = 0;
    cur = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (run_len == 0) begin
        cur     = 1'($urandom_range(0, 1));
        run_len = $urandom_range(1, 20);
      end
      run_len--;
      step(cur, ($urandom_range(0, 15) == 0));
      check($sformatf("rand[%0d]", i), model_exp());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
